// File: rtl/alu_pipe.sv
// Two-stage pipelined ARM data-processing ALU with an internal NZCV register.
// S1 holds the accepted operands; S2 is the registered result presented to writeback.
module alu_pipe #(
   parameter int         DATA_WIDTH  = 32,
   parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic [3:0]            alu_control,
   input  logic                  set_flags,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic [3:0]            nzcv,
   output logic                  result_writeback,
   output logic                  nzcv_writeback,
   output logic [3:0]            flags
);

   typedef enum logic [3:0] {
      OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
      OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
      OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
      OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
   } alu_op_e;

   logic                  s1Valid_q;
   logic [DATA_WIDTH-1:0] s1A_q, s1B_q;
   alu_op_e               s1Op_q;
   logic                  s1S_q;

   logic                  outValid_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic [3:0]            nzcv_q;
   logic                  resultWb_q, nzcvWb_q;
   logic [3:0]            flags_q;

   logic                  s2CanLoad, s2Load, acceptIn;
   logic [DATA_WIDTH-1:0] addX, addY, result_d;
   logic                  carryIn, isArith, flagOnly;
   logic [DATA_WIDTH:0]   sum;
   logic [3:0]            nzcv_d;

   assign s2CanLoad = !outValid_q || out_ready;
   assign in_ready  = (!s1Valid_q || s2CanLoad) && !flush;
   assign acceptIn  = in_valid && in_ready;
   assign s2Load    = s1Valid_q && s2CanLoad && !flush;

   // Subtracts are folded into x + ~y + cin so the carry out is already NOT borrow.
   always_comb begin
      addX     = s1A_q;
      addY     = s1B_q;
      carryIn  = 1'b0;
      isArith  = 1'b1;
      result_d = '0;
      unique case (s1Op_q)
         OP_SUB, OP_CMP: begin addY = ~s1B_q; carryIn = 1'b1; end
         OP_RSB:         begin addX = s1B_q; addY = ~s1A_q; carryIn = 1'b1; end
         OP_ADD, OP_CMN: carryIn = 1'b0;
         OP_ADC:         carryIn = flags_q[1];
         OP_SBC:         begin addY = ~s1B_q; carryIn = flags_q[1]; end
         OP_RSC:         begin addX = s1B_q; addY = ~s1A_q; carryIn = flags_q[1]; end
         default:        isArith = 1'b0;
      endcase
      sum = {1'b0, addX} + {1'b0, addY} + {{DATA_WIDTH{1'b0}}, carryIn};
      if (isArith) begin
         result_d = sum[DATA_WIDTH-1:0];
      end else begin
         unique case (s1Op_q)
            OP_AND, OP_TST: result_d = s1A_q & s1B_q;
            OP_EOR, OP_TEQ: result_d = s1A_q ^ s1B_q;
            OP_ORR:         result_d = s1A_q | s1B_q;
            OP_MOV:         result_d = s1B_q;
            OP_BIC:         result_d = s1A_q & ~s1B_q;
            default:        result_d = ~s1B_q;
         endcase
      end
      nzcv_d[3] = result_d[DATA_WIDTH-1];
      nzcv_d[2] = (result_d == '0);
      nzcv_d[1] = isArith ? sum[DATA_WIDTH] : flags_q[1];
      nzcv_d[0] = isArith ? ((addX[DATA_WIDTH-1] == addY[DATA_WIDTH-1]) &&
                             (sum[DATA_WIDTH-1] != addX[DATA_WIDTH-1]))
                          : flags_q[0];
      flagOnly = (s1Op_q == OP_TST) || (s1Op_q == OP_TEQ) ||
                 (s1Op_q == OP_CMP) || (s1Op_q == OP_CMN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1Valid_q <= 1'b0;
         s1A_q     <= '0;
         s1B_q     <= '0;
         s1Op_q    <= OP_AND;
         s1S_q     <= 1'b0;
      end else if (flush) begin
         s1Valid_q <= 1'b0;
      end else if (acceptIn) begin
         s1Valid_q <= 1'b1;
         s1A_q     <= operand_a;
         s1B_q     <= operand_b;
         s1Op_q    <= alu_op_e'(alu_control);
         s1S_q     <= set_flags;
      end else if (s2Load) begin
         s1Valid_q <= 1'b0;
      end
   end

   // Flags commit on the S2 load edge so the op following in S1 sees the new carry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         outValid_q <= 1'b0;
         result_q   <= '0;
         nzcv_q     <= 4'b0000;
         resultWb_q <= 1'b0;
         nzcvWb_q   <= 1'b0;
         flags_q    <= FLAGS_RESET;
      end else if (flush) begin
         outValid_q <= 1'b0;
      end else if (s2Load) begin
         outValid_q <= 1'b1;
         result_q   <= result_d;
         nzcv_q     <= nzcv_d;
         resultWb_q <= !flagOnly;
         nzcvWb_q   <= flagOnly || s1S_q;
         if (flagOnly || s1S_q) flags_q <= nzcv_d;
      end else if (out_ready) begin
         outValid_q <= 1'b0;
      end
   end

   assign out_valid        = outValid_q;
   assign result           = result_q;
   assign nzcv             = nzcv_q;
   assign result_writeback = resultWb_q;
   assign nzcv_writeback   = nzcvWb_q;
   assign flags            = flags_q;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the combinational ARM7TDMI data-processing ALU.
- Implements the same 16 ARM data-processing opcodes at width DATA_WIDTH.
- Holds an architectural NZCV flag register internally, so ADC/SBC/RSC take carry-in from it.
- Sits between the register-read/shifter stage and writeback: valid/ready handshake on both sides, plus a flush input for branch mispredict and exception.

Parameters:
DATA_WIDTH, 32, operand/result width; legal values are 8 or more.
FLAGS_RESET, 4'b0000, reset value of the internal NZCV register.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous; discards all in-flight ops.
in_valid  input  1  operation offered.
in_ready  output  1  block accepts the op this cycle.
operand_a  input  DATA_WIDTH  Rn.
operand_b  input  DATA_WIDTH  shifter operand.
alu_control  input  4  opcode: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, 10 CMP, 11 CMN, 12 ORR, 13 MOV, 14 BIC, 15 MVN.
set_flags  input  1  S bit.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
result  output  DATA_WIDTH  registered result.
nzcv  output  4  registered flags produced by this op ({N,Z,C,V}).
result_writeback  output  1  Rd must be written.
nzcv_writeback  output  1  CPSR flags were updated by this op.
flags  output  4  current internal NZCV register.

Behaviour:
- Reset (reset_n low, async): S1 and S2 valid bits = 0, out_valid = 0, result = 0, nzcv = 0, result_writeback = 0, nzcv_writeback = 0, flags = FLAGS_RESET.
- Reset asserted mid-operation: in-flight ops are lost and flags are not updated.
- Stage 1 (S1) register: captures a, b, opcode and S when in_valid && in_ready.
- Stage 2 (S2 / output) register: loads the computed result from S1 when S1 is valid and (!out_valid || out_ready).
- in_ready = !s1_valid || s2_can_load. Full throughput is 1 op/cycle. Accept-to-out_valid latency is 2 cycles.
- Holding: while out_valid && !out_ready, the outputs are held stable and S1 holds. in_ready is 0 if S1 is also full.
- Arithmetic, computed at width DATA_WIDTH+1:
  - SUB = a-b; RSB = b-a; ADD = a+b; ADC = a+b+C.
  - SBC = a-b-!C; RSC = b-a-!C; CMP as SUB; CMN as ADD.
  - C = carry out. For subtracts, C = NOT borrow.
  - V = two's-complement signed overflow of the DATA_WIDTH result.
  - Wrap-around: the result is the low DATA_WIDTH bits.
- Logical: AND, EOR, TST = a&b; TEQ = a^b; ORR = a|b; MOV = b; BIC = a&~b; MVN = ~b.
  - Logical ops compute N and Z only. C and V pass through from the flag register unchanged.
- N = result MSB; Z = (result == 0).
- Writeback rules:
  - TST/TEQ/CMP/CMN: result_writeback = 0, nzcv_writeback = 1 regardless of set_flags.
  - All other opcodes: result_writeback = 1, nzcv_writeback = set_flags.
- Flag register update: on the same edge the op loads into S2, and only if nzcv_writeback for that op.
  - The next op in S1 therefore sees the updated C, so back-to-back ADC chains need no stall.
- Carry-in source: taken from the flag register at S1 compute time, never from a dropped op.
- flush (synchronous, priority over everything except reset):
  - Clears the S1 and S2 valid bits and out_valid.
  - An op that would load into S2 on the flush edge does not update the flags.
  - An input offered on the flush edge is not accepted; in_ready is forced to 0 that cycle.
  - The flag register otherwise keeps its value.
- Simultaneous out_ready and a new S1 load: S2 takes the new op on the same edge; no bubble.

Test Plan:
- Reset: reset_n low, W=32 -> out_valid=0, flags=0000, in_ready=1 after release. Then ADD a=5, b=3, S=1 -> out_valid 2 cycles later, result=8, nzcv=0000, result_writeback=1, nzcv_writeback=1.
- Carry chain: ADDS a=0xFFFFFFFF, b=1 -> result=0, nzcv=0110. Back-to-back next cycle ADC a=10, b=15 -> result=26 with no stall.
- Flag-only op: CMP a=5, b=10, S=0 -> result_writeback=0, nzcv_writeback=1, nzcv=1000. Then SBC a=15, b=8 -> result=6.
- Logical preserves C/V: with flags=0011, ANDS a=0xCC, b=0xAA -> result=0x88, nzcv=0011. Then MVN b=0, S=0 -> result=0xFFFFFFFF, flags unchanged.
- Backpressure: stream 4 ADDs with out_ready low for 3 cycles -> in_ready drops after 2 accepted ops, outputs stay stable. Releasing out_ready gives results in order, no duplicates or losses.
- Flush: SUBS 0x80000000-1 in S1 and flush asserted -> no out_valid, flags unchanged. A following SUBS gives result=0x7FFFFFFF, nzcv=0011.
